// File: rtl/execute_muldiv_pkg.sv
// Shared op codes, FSM states and op decode for the multiply/divide unit.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package execute_muldiv_pkg;

    typedef enum logic [2:0] {
        MDOP_MULT  = 3'd0,
        MDOP_MULTU = 3'd1,
        MDOP_DIV   = 3'd2,
        MDOP_DIVU  = 3'd3,
        MDOP_MADD  = 3'd4,
        MDOP_MADDU = 3'd5,
        MDOP_MSUB  = 3'd6,
        MDOP_MSUBU = 3'd7
    } mdop_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    typedef struct packed {
        logic is_div;
        logic is_signed;
        logic acc_add;
        logic acc_sub;
    } mdop_dec_t;

    // Anything not recognised decodes as MULTU (plain unsigned product).
    function automatic mdop_dec_t mdop_decode(input logic [2:0] op);
        mdop_dec_t d;
        d = '0;
        case (op)
            MDOP_MULT:  d.is_signed = 1'b1;
            MDOP_DIV:   begin d.is_div = 1'b1; d.is_signed = 1'b1; end
            MDOP_DIVU:  d.is_div = 1'b1;
            MDOP_MADD:  begin d.is_signed = 1'b1; d.acc_add = 1'b1; end
            MDOP_MADDU: d.acc_add = 1'b1;
            MDOP_MSUB:  begin d.is_signed = 1'b1; d.acc_sub = 1'b1; end
            MDOP_MSUBU: d.acc_sub = 1'b1;
            default:    d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/execute_muldiv_divider.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// Latency: WIDTH steps after load; last_o is high during the final step.
// Backpressure: none; the owner only pulses step_i while it wants progress.
module execute_muldiv_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             last_o,
    output logic             zero_o
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             zero_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // One iteration: shift in next dividend bit, keep the subtraction if it did not borrow.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        rem_d   = diff[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], 1'b1};
        if (diff[WIDTH]) begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Iteration registers; the quotient register starts out holding the dividend.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else if (load_i) begin
            rem_q  <= '0;
            quo_q  <= dividend_i;
            dvs_q  <= divisor_i;
            cnt_q  <= '0;
            zero_q <= (divisor_i == '0);
        end else if (step_i) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign quo_o  = quo_q;
    assign rem_o  = rem_q;
    assign last_o = (cnt_q == CW'(WIDTH - 1));
    assign zero_o = zero_q;

endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle MULT/DIV/MADD/MSUB unit producing {HI,LO}; holds busy to stall execute.
// Latency: mul-class MUL_LATENCY cycles, divide WIDTH+2, divide-by-zero 2 (accept edge = cycle 0).
// Backpressure: start is ignored unless IDLE; cancel aborts any state without a done pulse.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int PW   = 2 * WIDTH;
    localparam int PIPE = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
    localparam int MCW  = $clog2(MUL_LATENCY + 1);
    localparam logic [MCW-1:0] MCNT_INIT = MCW'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

    md_state_e        state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [PW-1:0]    acc_q;
    logic [MCW-1:0]   mcnt_q;
    logic [PW-1:0]    prod_q [PIPE];
    logic [WIDTH-1:0] hi_out_q, hi_out_d, lo_out_q, lo_out_d;
    logic             out_we, accept, div_step;

    mdop_dec_t        dec_q, fin_dec;
    logic             a_neg_in, b_neg_in, fin_neg, q_neg, r_neg;
    logic [WIDTH-1:0] a_mag_in, b_mag_in, div_quo, div_rem, div_lo, div_hi;
    logic [PW-1:0]    mag_prod_in, fin_mag, fin_acc, fin_p, mul_res;
    logic             div_last, div_zero;

    assign dec_q  = mdop_decode(op_q);
    assign accept = (state_q == ST_IDLE) && start && !cancel;

    // Operand magnitudes at accept time feed both the divider load and the first product stage.
    always_comb begin
        a_neg_in    = mdop_decode(op).is_signed & opA[WIDTH-1];
        b_neg_in    = mdop_decode(op).is_signed & opB[WIDTH-1];
        a_mag_in    = a_neg_in ? -opA : opA;
        b_mag_in    = b_neg_in ? -opB : opB;
        mag_prod_in = PW'(a_mag_in) * PW'(b_mag_in);
    end

    // With a single-cycle multiply the last stage works straight off the inputs.
    generate
        if (MUL_LATENCY == 1) begin : g_lat1
            assign fin_dec = mdop_decode(op);
            assign fin_mag = mag_prod_in;
            assign fin_acc = {hi_in, lo_in};
            assign fin_neg = a_neg_in ^ b_neg_in;
        end else begin : g_latn
            assign fin_dec = dec_q;
            assign fin_mag = prod_q[PIPE-1];
            assign fin_acc = acc_q;
            assign fin_neg = dec_q.is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        end
    endgenerate

    // Last multiply stage: sign fix then optional accumulate, all modulo 2^(2*WIDTH).
    always_comb begin
        fin_p   = fin_neg ? -fin_mag : fin_mag;
        mul_res = fin_p;
        if (fin_dec.acc_add) begin
            mul_res = fin_acc + fin_p;
        end else if (fin_dec.acc_sub) begin
            mul_res = fin_acc - fin_p;
        end
    end

    // Divide sign fix: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        q_neg  = dec_q.is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg  = dec_q.is_signed & a_q[WIDTH-1];
        div_lo = q_neg ? -div_quo : div_quo;
        div_hi = r_neg ? -div_rem : div_rem;
        if (div_zero) begin
            div_lo = '1;
            div_hi = a_q;
        end
    end

    // Next state and result-register write enable; cancel overrides everything.
    always_comb begin
        state_d  = state_q;
        out_we   = 1'b0;
        hi_out_d = hi_out_q;
        lo_out_d = lo_out_q;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (mdop_decode(op).is_div) begin
                        state_d = (opB == '0) ? ST_FIX : ST_DIV;
                    end else if (MUL_LATENCY == 1) begin
                        state_d  = ST_DONE;
                        out_we   = 1'b1;
                        {hi_out_d, lo_out_d} = mul_res;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                if (mcnt_q == '0) begin
                    state_d  = ST_DONE;
                    out_we   = 1'b1;
                    {hi_out_d, lo_out_d} = mul_res;
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (div_last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d  = ST_DONE;
                out_we   = 1'b1;
                hi_out_d = div_hi;
                lo_out_d = div_lo;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (cancel) begin
            state_d  = ST_IDLE;
            out_we   = 1'b0;
            div_step = 1'b0;
        end
    end

    // State, latched operands, multiply pipeline and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcnt_q   <= '0;
            hi_out_q <= '0;
            lo_out_q <= '0;
            for (int k = 0; k < PIPE; k++) prod_q[k] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= op;
                a_q       <= opA;
                b_q       <= opB;
                acc_q     <= {hi_in, lo_in};
                mcnt_q    <= MCNT_INIT;
                prod_q[0] <= mag_prod_in;
            end else if (state_q == ST_MUL && mcnt_q != '0) begin
                mcnt_q <= mcnt_q - 1'b1;
            end
            for (int k = 1; k < PIPE; k++) prod_q[k] <= prod_q[k-1];
            if (out_we) begin
                hi_out_q <= hi_out_d;
                lo_out_q <= lo_out_d;
            end
        end
    end

    execute_muldiv_divider #(.WIDTH(WIDTH)) u_divider (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept && mdop_decode(op).is_div),
        .step_i     (div_step),
        .dividend_i (a_mag_in),
        .divisor_i  (b_mag_in),
        .quo_o      (div_quo),
        .rem_o      (div_rem),
        .last_o     (div_last),
        .zero_o     (div_zero)
    );

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign hi_out = hi_out_q;
    assign lo_out = lo_out_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Randomized + directed bench for execute_muldiv with a queue scoreboard.
// Latency: expected done cycle is carried with every scoreboard entry.
// Backpressure: driver waits for busy low before issuing each op.
module tb_execute_muldiv;
    import execute_muldiv_pkg::*;

    localparam int W  = 32;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          cancel = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  opA = '0, opB = '0, hi_in = '0, lo_in = '0;
    logic          busy, done;
    logic [W-1:0]  hi_out, lo_out;

    execute_muldiv #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .hi_in  (hi_in),
        .lo_in  (lo_in),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_chk  = 0;
    int           n_pass = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain 64-bit arithmetic straight from the op definitions.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] a, b, h, l);
        longint       sa = $signed(a);
        longint       sb_ = $signed(b);
        logic [63:0]  acc = {h, l};
        logic [63:0]  ps = sa * sb_;
        logic [63:0]  pu = {32'd0, a} * {32'd0, b};
        logic [63:0]  q, r;
        case (o)
            MDOP_MULT:  return ps;
            MDOP_MADD:  return acc + ps;
            MDOP_MADDU: return acc + pu;
            MDOP_MSUB:  return acc - ps;
            MDOP_MSUBU: return acc - pu;
            MDOP_DIV, MDOP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (o == MDOP_DIV) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                    q = sa / sb_;
                    r = sa % sb_;
                end else begin
                    q = {32'd0, a} / {32'd0, b};
                    r = {32'd0, a} % {32'd0, b};
                end
                return {r[31:0], q[31:0]};
            end
            default:    return pu;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [W-1:0] b);
        if (o == MDOP_DIV || o == MDOP_DIVU) return (b == 0) ? 2 : W + 2;
        return ML;
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, b, h, l, input bit track);
        int          t = 0;
        exp_t        e;
        logic [63:0] r;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_chk++;
            $display("FAIL idle_wait: busy still 1 after %0d cycles, required 0", t);
        end
        op = o; opA = a; opB = b; hi_in = h; lo_in = l; start = 1'b1;
        if (track) begin
            r     = model(o, a, b, h, l);
            e.hi  = r[63:32];
            e.lo  = r[31:0];
            e.cyc = cyc + latency(o, b);
            sb.push_back(e);
            last_hi = e.hi;
            last_lo = e.lo;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest expectation, value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = sb.pop_front();
                check("result_hi", hi_out, e.hi);
                check("result_lo", lo_out, e.lo);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        rst = 1'b1;
        @(negedge clk);

        // MULT -3 * 7 with busy profile
        issue(MDOP_MULT, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 1'b1);
        check("mult_busy_c1", busy, 1);
        @(negedge clk);
        check("mult_busy_c2", busy, 1);
        check("mult_done_c2", done, 1);
        @(negedge clk);
        check("mult_busy_c3", busy, 0);

        issue(MDOP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1);
        issue(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b1);
        issue(MDOP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1);
        issue(MDOP_DIVU, 32'h1234, 32'd0, 32'd0, 32'd0, 1'b1);
        issue(MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);

        // Back-to-back MULTU: second accepted the cycle after the first done
        issue(MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
        issue(MDOP_MULTU, 32'd12345, 32'd678, 32'd0, 32'd0, 1'b1);

        // start while busy is ignored
        issue(MDOP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b1);
        op = MDOP_MULT; opA = 32'd5; opB = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // cancel at cycle 10 of a DIV: idle at 11, no done, results held
        issue(MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", busy, 0);
        repeat (40) @(negedge clk);
        check("cancel_hold_hi", hi_out, last_hi);
        check("cancel_hold_lo", lo_out, last_lo);

        // cancel and start together in IDLE: no accept
        op = MDOP_MULT; opA = 32'd3; opB = 32'd3; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check("cancel_start_busy", busy, 0);

        // reset at cycle 5 of a DIV
        issue(MDOP_DIV, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hi", hi_out, 0);
        check("midrst_lo", lo_out, 0);
        rst = 1'b1;
        last_hi = '0;
        last_lo = '0;

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), $urandom, $urandom, 1'b1);
        end

        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(sb.size()), 0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
